// File: rtl/ntt_ctrl_pkg.sv
// Shared constants, mode encodings, FSM states and the write-back delay-line
// entry for the Kyber NTT sequencing controller.
package ntt_ctrl_pkg;

    localparam int N            = 256;
    localparam int NUM_LAYERS   = 7;
    localparam int BF_PER_LAYER = 128;

    localparam logic [1:0] MODE_NTT  = 2'b00;
    localparam logic [1:0] MODE_INTT = 2'b01;
    localparam logic [1:0] MODE_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] addr_a;
        logic [7:0] addr_b;
    } wb_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address/twiddle map (layer, index, inv) -> (j, j+len, tw).
// INTT ordering is only built when NTT_CTRL_INTT_EN is defined.
module ntt_addr_gen (
    input  logic [2:0] layer,
    input  logic [6:0] idx,
    input  logic       inv,
    output logic [7:0] addr_a,
    output logic [7:0] addr_b,
    output logic [6:0] tw
);

    logic [7:0] len;
    logic [7:0] mask;
    logic [7:0] idx_ext;
    logic [7:0] j;
    logic [6:0] grp;

`ifndef NTT_CTRL_INTT_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // len is a power of two, so i/len and i mod len reduce to shifts and masks
    always_comb begin
        idx_ext = {1'b0, idx};
        len     = 8'd128 >> layer;
        grp     = idx >> (3'd7 - layer);
        tw      = (7'd1 << layer) + grp;
`ifdef NTT_CTRL_INTT_EN
        if (inv) begin
            len = 8'd2 << layer;
            grp = idx >> (layer + 3'd1);
            tw  = (7'd127 >> layer) - grp;
        end
`endif
        mask   = len - 8'd1;
        j      = ((idx_ext & ~mask) << 1) | (idx_ext & mask);
        addr_a = j;
        addr_b = j + len;
    end

endmodule

// File: rtl/ntt_ctrl.sv
// Kyber NTT/INTT sequencing controller: FSM, layer/butterfly counters and the
// write-back delay line. Define NTT_CTRL_INTT_EN to enable inverse transforms.
module ntt_ctrl
    import ntt_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);

    localparam int PIPE_LAT = RD_LAT + BF_LAT;
    localparam int DRAIN_W  = $clog2(PIPE_LAT + 1);

    state_e             state_q, state_d;
    logic [2:0]         layer_q, layer_d;
    logic [6:0]         idx_q, idx_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               inv_q, inv_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [7:0]         rd_addr_a_q, rd_addr_a_d;
    logic [7:0]         rd_addr_b_q, rd_addr_b_d;
    logic [6:0]         tw_addr_q, tw_addr_d;
    logic [1:0]         bf_mode_q, bf_mode_d;
    wb_t                wb_q [PIPE_LAT];
    wb_t                wb_d [PIPE_LAT];

    logic [7:0]         gen_a;
    logic [7:0]         gen_b;
    logic [6:0]         gen_tw;
    logic               active_d;

`ifndef NTT_CTRL_INTT_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // Addresses are generated from the next-state counters so that every
    // output can be registered without adding a cycle of read latency.
    ntt_addr_gen u_addr_gen (
        .layer  (layer_d),
        .idx    (idx_d),
        .inv    (inv_d),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw     (gen_tw)
    );

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        inv_d   = inv_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    layer_d = 3'd0;
                    idx_d   = 7'd0;
`ifdef NTT_CTRL_INTT_EN
                    inv_d   = inv;
`else
                    inv_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (idx_q == 7'(BF_PER_LAYER - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(PIPE_LAT - 1)) begin
                    if (layer_q == 3'(NUM_LAYERS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        layer_d = layer_q + 3'd1;
                        idx_d   = 7'd0;
                    end
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        active_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        busy_d      = active_d;
        done_d      = (state_d == ST_DONE);
        rd_en_d     = (state_d == ST_RUN);
        rd_addr_a_d = rd_en_d ? gen_a : 8'd0;
        rd_addr_b_d = rd_en_d ? gen_b : 8'd0;
        tw_addr_d   = rd_en_d ? gen_tw : 7'd0;
        bf_mode_d   = active_d ? (inv_d ? MODE_INTT : MODE_NTT) : MODE_IDLE;

        wb_d[0] = {rd_en_q, rd_addr_a_q, rd_addr_b_q};
        for (int k = 1; k < PIPE_LAT; k++) begin
            wb_d[k] = wb_q[k-1];
        end
    end

    // Reset also flushes the delay line so no stale write can land afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            layer_q     <= 3'd0;
            idx_q       <= 7'd0;
            drain_q     <= '0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= 8'd0;
            rd_addr_b_q <= 8'd0;
            tw_addr_q   <= 7'd0;
            bf_mode_q   <= MODE_IDLE;
            for (int k = 0; k < PIPE_LAT; k++) begin
                wb_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            inv_q       <= inv_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            bf_mode_q   <= bf_mode_d;
            for (int k = 0; k < PIPE_LAT; k++) begin
                wb_q[k] <= wb_d[k];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;
    assign bf_mode   = bf_mode_q;
    assign wr_en     = wb_q[PIPE_LAT-1].valid;
    assign wr_addr_a = wb_q[PIPE_LAT-1].addr_a;
    assign wr_addr_b = wb_q[PIPE_LAT-1].addr_b;

endmodule
